// File: rtl/elevator_scan_ctrl.sv
// Elevator car controller: latches floor calls inside a runtime service window
// and serves them with a SCAN sweep, modelling per-floor travel and door dwell.
//
// state       | meaning
// S_IDLE      | parked at floor_q, choosing the next action
// S_MOVE_UP   | travelling one floor up, timer counts down the travel time
// S_MOVE_DOWN | travelling one floor down, timer counts down the travel time
// S_DOOR_OPEN | door open at floor_q, timer counts down the dwell
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [NUM_FLOORS-1:0] req_i,
    input  logic [FLOOR_W-1:0]    min_floor_i,
    input  logic [FLOOR_W-1:0]    max_floor_i,
    output logic [FLOOR_W-1:0]    floor_o,
    output logic                  dir_up_o,
    output logic                  moving_o,
    output logic                  door_open_o,
    output logic                  arrive_o,
    output logic [NUM_FLOORS-1:0] pending_o
);

    localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]      T_TRAVEL = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0]      T_DOOR   = TW'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] TOP      = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] ONE_FL   = FLOOR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN
    } state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic                    dir_up_q, dir_up_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    arrive_q, arrive_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;

    logic [NUM_FLOORS-1:0]   mask;
    logic [NUM_FLOORS-1:0]   req_eff;
    logic [NUM_FLOORS-1:0]   clr;
    logic [FLOOR_W-1:0]      up_floor;
    logic [FLOOR_W-1:0]      dn_floor;
    logic                    win_ok;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        logic r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i > int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        logic r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    // Parking only pulls the car toward the window; it never pushes past the shaft ends.
    function automatic logic park_up(input logic [FLOOR_W-1:0] f);
        return (f < min_floor_i) && (f != TOP);
    endfunction

    function automatic logic park_dn(input logic [FLOOR_W-1:0] f);
        return win_ok && (f > max_floor_i) && (f != '0);
    endfunction

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            mask[i] = (i >= int'(min_floor_i)) && (i <= int'(max_floor_i));
    end

    assign win_ok   = (min_floor_i <= max_floor_i);
    assign up_floor = floor_q + ONE_FL;
    assign dn_floor = floor_q - ONE_FL;

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        arrive_d = 1'b0;
        clr      = '0;
        req_eff  = req_i & mask;
        if (state_q == S_DOOR_OPEN)
            req_eff = req_eff & ~onehot(floor_q);

        case (state_q)
            S_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d = S_DOOR_OPEN;
                    timer_d = T_DOOR;
                    clr     = onehot(floor_q);
                end else if (en_i) begin
                    timer_d = T_TRAVEL;
                    if (dir_up_q && any_above(pending_q, floor_q)) begin
                        state_d = S_MOVE_UP;
                    end else if (dir_up_q && any_below(pending_q, floor_q)) begin
                        state_d  = S_MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else if (!dir_up_q && any_below(pending_q, floor_q)) begin
                        state_d = S_MOVE_DOWN;
                    end else if (!dir_up_q && any_above(pending_q, floor_q)) begin
                        state_d  = S_MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (park_up(floor_q)) begin
                        state_d  = S_MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (park_dn(floor_q)) begin
                        state_d  = S_MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else begin
                        timer_d = timer_q;
                    end
                end
            end
            S_MOVE_UP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (floor_q == TOP) begin
                    state_d = S_IDLE;
                end else begin
                    floor_d  = up_floor;
                    arrive_d = 1'b1;
                    if (pending_q[up_floor]) begin
                        state_d = S_DOOR_OPEN;
                        timer_d = T_DOOR;
                        clr     = onehot(up_floor);
                    end else if (en_i && (any_above(pending_q, up_floor) || park_up(up_floor))) begin
                        timer_d = T_TRAVEL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (floor_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    floor_d  = dn_floor;
                    arrive_d = 1'b1;
                    if (pending_q[dn_floor]) begin
                        state_d = S_DOOR_OPEN;
                        timer_d = T_DOOR;
                        clr     = onehot(dn_floor);
                    end else if (en_i && (any_below(pending_q, dn_floor) || park_dn(dn_floor))) begin
                        timer_d = T_TRAVEL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DOOR_OPEN: begin
                if ((req_i & onehot(floor_q)) != '0) begin
                    timer_d = T_DOOR;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pending_d = (pending_q | req_eff) & ~clr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            timer_q   <= '0;
            arrive_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            timer_q   <= timer_d;
            arrive_q  <= arrive_d;
            pending_q <= pending_d;
        end
    end

    assign floor_o     = floor_q;
    assign dir_up_o    = dir_up_q;
    assign moving_o    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign door_open_o = (state_q == S_DOOR_OPEN);
    assign arrive_o    = arrive_q;
    assign pending_o   = pending_q;

endmodule
